// File: rtl/ftdi_tx_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ftdi_tx_packetizer
// Description : Frames 16-bit ADC samples into a byte stream for the FTDI
//               synchronous-FIFO writer. Each frame carries a header byte, a
//               sequence number, SAMPLES_PER_PKT samples (MSB first) and,
//               when FTDI_PKT_CHECKSUM_EN is defined, an 8-bit additive
//               checksum over the sequence and sample bytes.
//               The block lives entirely in the ftdiclk domain.
// Options     : FTDI_PKT_CHECKSUM_EN (define) - append checksum byte
// Parameters  : SAMPLES_PER_PKT - samples per frame (1..255)
//               HEADER_BYTE     - first byte of each frame
// Ports       : ftdiclk       in   FTDI clock
//               reset         in   asynchronous active-high reset
//               sample_data   in   [15:0] ADC sample word
//               sample_valid  in   sample_data valid
//               sample_ready  out  sample accepted when valid && ready
//               byte_data     out  [7:0] byte toward FTDI writer
//               byte_valid    out  byte_data valid
//               byte_ready    in   writer accepts byte this cycle
//               pkt_busy      out  frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_tx_packetizer #(
  parameter int unsigned SAMPLES_PER_PKT = 32,
  parameter logic [7:0]  HEADER_BYTE     = 8'hA5
) (
  input  logic        ftdiclk,
  input  logic        reset,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        pkt_busy
);

  // r_cnt holds samples already sent, so the last LSB is seen at N-1.
  localparam logic [7:0] c_last_cnt = 8'(SAMPLES_PER_PKT - 1);

`ifdef FTDI_PKT_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_LOAD = 3'd3,
    ST_MSB  = 3'd4,
    ST_LSB  = 3'd5,
    ST_CSUM = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_LOAD = 3'd3,
    ST_MSB  = 3'd4,
    ST_LSB  = 3'd5
  } state_t;
`endif

  state_t      r_state;
  logic [7:0]  r_seq;
  logic [7:0]  r_cnt;
  logic [15:0] r_sample;
`ifdef FTDI_PKT_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic w_byte_fire;
  assign w_byte_fire = byte_valid && byte_ready;

  always_ff @(posedge ftdiclk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_seq    <= 8'd0;
      r_cnt    <= 8'd0;
      r_sample <= 16'd0;
`ifdef FTDI_PKT_CHECKSUM_EN
      r_csum   <= 8'd0;
`endif
    end else begin
      case (r_state)
        // Start a frame as soon as data is offered; the sample itself is
        // consumed later in LOAD.
        ST_IDLE: begin
          if (sample_valid) begin
            r_state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_byte_fire) begin
            r_cnt   <= 8'd0;
`ifdef FTDI_PKT_CHECKSUM_EN
            r_csum  <= 8'd0;
`endif
            r_state <= ST_SEQ;
          end
        end
        ST_SEQ: begin
          if (w_byte_fire) begin
`ifdef FTDI_PKT_CHECKSUM_EN
            r_csum  <= r_seq;
`endif
            r_state <= ST_LOAD;
          end
        end
        // sample_ready is high only here, so valid alone completes the handshake.
        ST_LOAD: begin
          if (sample_valid) begin
            r_sample <= sample_data;
            r_state  <= ST_MSB;
          end
        end
        ST_MSB: begin
          if (w_byte_fire) begin
`ifdef FTDI_PKT_CHECKSUM_EN
            r_csum  <= r_csum + r_sample[15:8];
`endif
            r_state <= ST_LSB;
          end
        end
        ST_LSB: begin
          if (w_byte_fire) begin
`ifdef FTDI_PKT_CHECKSUM_EN
            r_csum <= r_csum + r_sample[7:0];
`endif
            r_cnt  <= r_cnt + 8'd1;
            if (r_cnt == c_last_cnt) begin
`ifdef FTDI_PKT_CHECKSUM_EN
              r_state <= ST_CSUM;
`else
              r_seq   <= r_seq + 8'd1;
              r_state <= ST_IDLE;
`endif
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
`ifdef FTDI_PKT_CHECKSUM_EN
        ST_CSUM: begin
          if (w_byte_fire) begin
            r_seq   <= r_seq + 8'd1;
            r_state <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are a pure decode of registered state, so they stay stable while
  // a byte waits for byte_ready and drop together with an async reset.
  always_comb begin
    byte_data    = 8'd0;
    byte_valid   = 1'b0;
    sample_ready = 1'b0;
    pkt_busy     = 1'b1;
    case (r_state)
      ST_IDLE: pkt_busy = 1'b0;
      ST_HDR: begin
        byte_data  = HEADER_BYTE;
        byte_valid = 1'b1;
      end
      ST_SEQ: begin
        byte_data  = r_seq;
        byte_valid = 1'b1;
      end
      ST_LOAD: sample_ready = 1'b1;
      ST_MSB: begin
        byte_data  = r_sample[15:8];
        byte_valid = 1'b1;
      end
      ST_LSB: begin
        byte_data  = r_sample[7:0];
        byte_valid = 1'b1;
      end
`ifdef FTDI_PKT_CHECKSUM_EN
      ST_CSUM: begin
        byte_data  = r_csum;
        byte_valid = 1'b1;
      end
`endif
      default: pkt_busy = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ftdi_tx_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ftdi_tx_packetizer
// Description : Directed self-checking bench for ftdi_tx_packetizer with
//               SAMPLES_PER_PKT=2. Expected frames follow the checksum option
//               the design is built with (FTDI_PKT_CHECKSUM_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ftdi_tx_packetizer;

  logic        ftdiclk      = 1'b0;
  logic        reset        = 1'b1;
  logic [15:0] sample_data  = 16'd0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready   = 1'b0;
  logic        pkt_busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sample_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  bit          toggle_ready = 1'b0;

  always #5 ftdiclk = ~ftdiclk;

  ftdi_tx_packetizer #(
    .SAMPLES_PER_PKT(2),
    .HEADER_BYTE    (8'hA5)
  ) dut (
    .ftdiclk     (ftdiclk),
    .reset       (reset),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .pkt_busy    (pkt_busy)
  );

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Main thread acts 2 time units after the edge; source/sink act at 1.
  task automatic tick();
    @(posedge ftdiclk);
    #2;
  endtask

  // Sample source: presents the head of sample_q, pops it after a handshake.
  initial begin : p_source
    bit taken;
    forever begin
      @(negedge ftdiclk);
      taken = sample_valid && sample_ready;
      @(posedge ftdiclk);
      #1;
      if (taken && sample_q.size() > 0) void'(sample_q.pop_front());
      if (sample_q.size() > 0) begin
        sample_valid = 1'b1;
        sample_data  = sample_q[0];
      end else begin
        sample_valid = 1'b0;
        sample_data  = 16'd0;
      end
    end
  end

  // Byte sink: records accepted bytes and checks stability under backpressure.
  initial begin : p_sink
    bit         held;
    logic [7:0] held_data;
    held      = 1'b0;
    held_data = 8'd0;
    forever begin
      @(negedge ftdiclk);
      if (held && !reset) begin
        check_value("hold_valid", 32'(byte_valid), 32'd1);
        check_value("hold_data", 32'(byte_data), 32'(held_data));
      end
      if (byte_valid && byte_ready) rx_q.push_back(byte_data);
      held      = byte_valid && !byte_ready;
      held_data = byte_data;
      @(posedge ftdiclk);
      #1;
      byte_ready = toggle_ready ? ~byte_ready : 1'b1;
    end
  end

  task automatic make_exp(input logic [7:0] seq, input logic [15:0] a,
                          input logic [15:0] b);
    logic [7:0] sum;
    sum = seq + a[15:8] + a[7:0] + b[15:8] + b[7:0];
    exp_q = '{8'hA5, seq, a[15:8], a[7:0], b[15:8], b[7:0]};
`ifdef FTDI_PKT_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic collect_frame(input string tag);
    int budget;
    budget = 0;
    while (rx_q.size() < exp_q.size() && budget < 300) begin
      tick();
      budget++;
    end
    check_value({tag, "_bytes_timeout"}, 32'(budget < 300), 32'd1);
    for (int i = 0; i < exp_q.size(); i++) begin
      check_value($sformatf("%s_b%0d", tag, i),
                  (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF,
                  32'(exp_q[i]));
    end
    budget = 0;
    while (pkt_busy && budget < 50) begin
      tick();
      budget++;
    end
    check_value({tag, "_busy_end"}, 32'(pkt_busy), 32'd0);
    check_value({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    rx_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_q.delete();
    tick();
    tick();
    @(negedge ftdiclk);
    reset = 1'b0;
    rx_q.delete();
    tick();
  endtask

  initial begin : p_main
    int budget;

    // Reset state
    tick();
    tick();
    check_value("rst_byte_valid", 32'(byte_valid), 32'd0);
    check_value("rst_sample_ready", 32'(sample_ready), 32'd0);
    check_value("rst_pkt_busy", 32'(pkt_busy), 32'd0);
    check_value("rst_byte_data", 32'(byte_data), 32'd0);
    @(negedge ftdiclk);
    reset = 1'b0;
    tick();
    check_value("idle_pkt_busy", 32'(pkt_busy), 32'd0);

    // Basic frame, seq 0
    exp_q = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef FTDI_PKT_CHECKSUM_EN
    exp_q.push_back(8'hBE);
`endif
    sample_q.push_back(16'h1234);
    sample_q.push_back(16'hABCD);
    collect_frame("t1");

    // Toggling byte_ready, seq 1
    toggle_ready = 1'b1;
    exp_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef FTDI_PKT_CHECKSUM_EN
    exp_q.push_back(8'hBF);
`endif
    sample_q.push_back(16'h1234);
    sample_q.push_back(16'hABCD);
    collect_frame("t2");
    toggle_ready = 1'b0;
    tick();
    tick();

    // Sample starvation in LOAD, seq 2
    sample_q.push_back(16'h1234);
    budget = 0;
    while (rx_q.size() < 4 && budget < 100) begin
      tick();
      budget++;
    end
    check_value("t3_first_sample", 32'(rx_q.size()), 32'd4);
    tick();
    for (int i = 0; i < 10; i++) begin
      check_value("t3_stall_byte_valid", 32'(byte_valid), 32'd0);
      check_value("t3_stall_sample_ready", 32'(sample_ready), 32'd1);
      check_value("t3_stall_busy", 32'(pkt_busy), 32'd1);
      tick();
    end
    make_exp(8'h02, 16'h1234, 16'hABCD);
    sample_q.push_back(16'hABCD);
    collect_frame("t3");

    // 257 frames from a fresh reset: seq runs 00..FF and wraps to 00
    do_reset();
    for (int f = 0; f < 257; f++) begin
      logic [15:0] a, b;
      a = {8'(f), 8'h5A};
      b = 16'(f * 257 + 1);
      make_exp(8'(f), a, b);
      sample_q.push_back(a);
      sample_q.push_back(b);
      collect_frame($sformatf("t4_f%0d", f));
    end

    // Reset mid-frame after the first sample MSB is accepted
    sample_q.push_back(16'h1234);
    sample_q.push_back(16'hABCD);
    budget = 0;
    while (rx_q.size() < 3 && budget < 100) begin
      tick();
      budget++;
    end
    check_value("t5_third_byte", (rx_q.size() >= 3) ? 32'(rx_q[2]) : 32'hFFFF_FFFF, 32'h12);
    reset = 1'b1;
    #1;
    check_value("t5_rst_byte_valid", 32'(byte_valid), 32'd0);
    check_value("t5_rst_busy", 32'(pkt_busy), 32'd0);
    check_value("t5_rst_sample_ready", 32'(sample_ready), 32'd0);
    check_value("t5_rst_byte_data", 32'(byte_data), 32'd0);
    do_reset();
    make_exp(8'h00, 16'h5555, 16'h0102);
    sample_q.push_back(16'h5555);
    sample_q.push_back(16'h0102);
    collect_frame("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
